spi_regfile_mc: RTL and testbench

Parametrised SPI-side register file for the multi-channel tuner front end. It holds the per-channel stream header bytes, which the SPI master writes into a shadow bank and activates atomically with a commit command. It returns per-channel byte-rate counters to the SPI read path, using a per-channel snapshot so that multi-byte values read back coherently. It sits between the SPI slave decoder and the stream muxer / rate-measurement logic, and generalises the earlier fixed 4-channel header/byterate block.

---
 rtl/spi_regmap_pkg.sv | 32 +++
 rtl/spi_rate_snap.sv | 38 +++
 rtl/spi_regfile_mc.sv | 173 +++++++++++++++++
 tb/tb_spi_regfile_mc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regmap_pkg.sv
// Shared register-map constants for the SPI tuner register blocks: default addresses,
// command codes, ID version field and the per-channel header default values.
package spi_regmap_pkg;

  localparam logic [6:0] HDR_BASE_DEF  = 7'h10;
  localparam logic [6:0] RATE_BASE_DEF = 7'h20;
  localparam logic [6:0] CMD_ADDR_DEF  = 7'h30;
  localparam logic [6:0] ID_ADDR_DEF   = 7'h31;

  localparam logic [7:0] CMD_COMMIT = 8'hA5;
  localparam logic [7:0] CMD_REVERT = 8'h5A;

  localparam logic [1:0] ID_VERSION = 2'b00;

  // Rate byte selector width; counters are at most 4 bytes wide.
  localparam int unsigned SEL_W = 2;

  // Byte 0 = PLP ID (channel), byte 1 = stream source (channel + 2), rest zero.
  function automatic logic [7:0] hdr_default(input int unsigned idx,
                                             input int unsigned hdr_bytes);
    int unsigned ch;
    int unsigned pos;
    logic [7:0]  val;
    ch  = idx / hdr_bytes;
    pos = idx % hdr_bytes;
    val = 8'h00;
    if (pos == 0) val = ch[7:0];
    else if (pos == 1) val = ch[7:0] + 8'd2;
    return val;
  endfunction

endpackage

// File: rtl/spi_rate_snap.sv
// One channel's byte-rate snapshot: captures the live word on a k=0 read so the
// remaining bytes of a multi-byte read come from the same sample.
module spi_rate_snap
  import spi_regmap_pkg::*;
#(
  parameter int unsigned RATE_BYTES = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [RATE_BYTES*8-1:0] live_word,
  input  logic                    capture,
  input  logic [SEL_W-1:0]        byte_sel,
  output logic [7:0]              rd_byte
);

  localparam int unsigned RW = RATE_BYTES * 8;

  logic [RW-1:0] snap_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      snap_q <= '0;
    end else if (capture) begin
      snap_q <= live_word;
    end
  end

  // k=0 is the MSB and always reads live; it is the byte that triggers the capture.
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < int'(RATE_BYTES); k++) begin
      if (int'(byte_sel) == k) begin
        rd_byte = (k == 0) ? live_word[RW-1 -: 8] : snap_q[(int'(RATE_BYTES) - 1 - k) * 8 +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_regfile_mc.sv
// Multi-channel SPI register file: shadow/active stream header banks with commit/revert,
// plus byte-rate readback. Optional snapshot path enabled by SPI_RATE_SNAPSHOT_EN.
module spi_regfile_mc
  import spi_regmap_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned HDR_BYTES  = 4,
  parameter int unsigned RATE_BYTES = 4,
  parameter logic [6:0]  HDR_BASE   = HDR_BASE_DEF,
  parameter logic [6:0]  RATE_BASE  = RATE_BASE_DEF,
  parameter logic [6:0]  CMD_ADDR   = CMD_ADDR_DEF,
  parameter logic [6:0]  ID_ADDR    = ID_ADDR_DEF,
  localparam int unsigned N_HDR     = N_CH * HDR_BYTES,
  localparam int unsigned HA_W      = (N_HDR > 1) ? $clog2(N_HDR) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [6:0]                   SPI_ADDRESS,
  input  logic [7:0]                   SPI_DATA,
  input  logic                         SPI_ENA,
  input  logic                         SPI_RD,
  output logic [7:0]                   DATA_TO_MISO,
  input  logic [HA_W-1:0]              header_byte_addr,
  output logic [7:0]                   header_byte,
  output logic                         hdr_update,
  input  logic [N_CH*RATE_BYTES*8-1:0] byterate_bus
);

  localparam int unsigned RW       = RATE_BYTES * 8;
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned HdrFirst = int'(HDR_BASE);
  localparam int unsigned HdrLast  = HdrFirst + N_HDR - 1;
  localparam int unsigned RateFirst = int'(RATE_BASE);
  localparam int unsigned RateLast = RateFirst + N_CH * RATE_BYTES - 1;
  localparam int unsigned CmdA     = int'(CMD_ADDR);
  localparam int unsigned IdA      = int'(ID_ADDR);

  function automatic bit overlaps(int unsigned a0, int unsigned a1,
                                  int unsigned b0, int unsigned b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  localparam bit CfgBad =
      (N_CH < 1) || (N_CH > 8) || (RATE_BYTES < 1) || (RATE_BYTES > 4) ||
      (HDR_BYTES < 1) || (HDR_BYTES > 8) || ((HDR_BYTES & (HDR_BYTES - 1)) != 0) ||
      (HdrLast > 127) || (RateLast > 127) ||
      overlaps(HdrFirst, HdrLast, RateFirst, RateLast) ||
      overlaps(HdrFirst, HdrLast, CmdA, CmdA) || overlaps(RateFirst, RateLast, CmdA, CmdA) ||
      overlaps(HdrFirst, HdrLast, IdA, IdA) || overlaps(RateFirst, RateLast, IdA, IdA) ||
      (CmdA == IdA);

  if (CfgBad) begin : g_cfg_err
    $error("spi_regfile_mc: illegal parameters or overlapping address windows");
  end

  // Address decode
  int unsigned      addr_u, hdr_off, rate_off, rate_div, rate_mod;
  logic             in_hdr, in_rate;
  logic [HA_W-1:0]  hdr_idx;
  logic [CH_W-1:0]  rate_ch;
  logic [SEL_W-1:0] rate_k;

  always_comb begin
    addr_u   = int'(SPI_ADDRESS);
    in_hdr   = (addr_u >= HdrFirst) && (addr_u <= HdrLast);
    in_rate  = (addr_u >= RateFirst) && (addr_u <= RateLast);
    hdr_off  = addr_u - HdrFirst;
    rate_off = addr_u - RateFirst;
    rate_div = rate_off / RATE_BYTES;
    rate_mod = rate_off % RATE_BYTES;
    hdr_idx  = hdr_off[HA_W-1:0];
    rate_ch  = rate_div[CH_W-1:0];
    rate_k   = rate_mod[SEL_W-1:0];
  end

  // Header banks
  logic [7:0] shadow_q [N_HDR];
  logic [7:0] active_q [N_HDR];
  logic       hdr_update_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < int'(N_HDR); i++) begin
        shadow_q[i] <= hdr_default(i, HDR_BYTES);
        active_q[i] <= hdr_default(i, HDR_BYTES);
      end
      hdr_update_q <= 1'b0;
    end else begin
      hdr_update_q <= 1'b0;
      if (SPI_ENA) begin
        if (in_hdr) begin
          shadow_q[hdr_idx] <= SPI_DATA;
        end else if (SPI_ADDRESS == CMD_ADDR) begin
          if (SPI_DATA == CMD_COMMIT) begin
            active_q     <= shadow_q;
            hdr_update_q <= 1'b1;
          end else if (SPI_DATA == CMD_REVERT) begin
            shadow_q <= active_q;
          end
        end
      end
    end
  end

  assign hdr_update = hdr_update_q;

  always_comb begin
    header_byte = 8'h00;
    if (int'(header_byte_addr) < N_HDR) header_byte = active_q[header_byte_addr];
  end

  // Rate readback
  logic [7:0] rate_byte;

`ifdef SPI_RATE_SNAPSHOT_EN
  localparam logic SnapBit = 1'b1;
  logic [7:0] snap_byte [N_CH];

  for (genvar c = 0; c < int'(N_CH); c++) begin : g_snap
    spi_rate_snap #(
      .RATE_BYTES (RATE_BYTES)
    ) u_snap (
      .CLK       (CLK),
      .RST       (RST),
      .live_word (byterate_bus[c*RW +: RW]),
      .capture   (SPI_RD && in_rate && (rate_ch == CH_W'(c)) && (rate_k == '0)),
      .byte_sel  (rate_k),
      .rd_byte   (snap_byte[c])
    );
  end

  always_comb begin
    rate_byte = 8'h00;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (int'(rate_ch) == c) rate_byte = snap_byte[c];
    end
  end
`else
  localparam logic SnapBit = 1'b0;
  logic unused_spi_rd;
  assign unused_spi_rd = SPI_RD;

  always_comb begin
    rate_byte = 8'h00;
    for (int c = 0; c < int'(N_CH); c++) begin
      for (int k = 0; k < int'(RATE_BYTES); k++) begin
        if ((int'(rate_ch) == c) && (int'(rate_k) == k)) begin
          rate_byte = byterate_bus[c * int'(RW) + (int'(RATE_BYTES) - 1 - k) * 8 +: 8];
        end
      end
    end
  end
`endif

  logic [7:0] id_byte, rd_mux, miso_q;

  assign id_byte = {3'(N_CH - 1), 2'(RATE_BYTES - 1), ID_VERSION, SnapBit};

  always_comb begin
    rd_mux = 8'h00;
    if (in_rate) rd_mux = rate_byte;
    else if (in_hdr) rd_mux = shadow_q[hdr_idx];
    else if (SPI_ADDRESS == ID_ADDR) rd_mux = id_byte;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) miso_q <= 8'h00;
    else      miso_q <= rd_mux;
  end

  assign DATA_TO_MISO = miso_q;

endmodule

// File: tb/tb_spi_regfile_mc.sv
// Randomized scoreboard bench for spi_regfile_mc against a behavioural register-map model.
module tb_spi_regfile_mc;

`ifdef SPI_RATE_SNAPSHOT_EN
  localparam bit SnapEn = 1'b1;
`else
  localparam bit SnapEn = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [6:0]   SPI_ADDRESS = '0;
  logic [7:0]   SPI_DATA = '0;
  logic         SPI_ENA = 1'b0;
  logic         SPI_RD = 1'b0;
  logic [7:0]   DATA_TO_MISO;
  logic [3:0]   header_byte_addr = '0;
  logic [7:0]   header_byte;
  logic         hdr_update;
  logic [127:0] byterate_bus = '0;

  spi_regfile_mc u_dut (
    .CLK              (CLK),
    .RST              (RST),
    .SPI_ADDRESS      (SPI_ADDRESS),
    .SPI_DATA         (SPI_DATA),
    .SPI_ENA          (SPI_ENA),
    .SPI_RD           (SPI_RD),
    .DATA_TO_MISO     (DATA_TO_MISO),
    .header_byte_addr (header_byte_addr),
    .header_byte      (header_byte),
    .hdr_update       (hdr_update),
    .byterate_bus     (byterate_bus)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model of the register map
  logic [7:0]  m_sh [16];
  logic [7:0]  m_act [16];
  logic [31:0] m_snap [4];
  int          exp_upd = 0;
  int          upd_cnt = 0;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_sh[i]  = (i % 4 == 0) ? 8'(i / 4) : (i % 4 == 1) ? 8'(i / 4 + 2) : 8'h00;
      m_act[i] = m_sh[i];
    end
    for (int c = 0; c < 4; c++) m_snap[c] = '0;
  endfunction

  function automatic logic [31:0] live_word(input int c);
    return byterate_bus[c*32 +: 32];
  endfunction

  function automatic logic [7:0] m_read(input logic [6:0] a);
    int ai, c, k;
    logic [31:0] w;
    ai = int'(a);
    if (ai >= 'h20 && ai < 'h30) begin
      c = (ai - 'h20) / 4;
      k = (ai - 'h20) % 4;
      w = (SnapEn && k != 0) ? m_snap[c] : live_word(c);
      return w[31 - 8*k -: 8];
    end
    if (ai >= 'h10 && ai < 'h20) return m_sh[ai - 'h10];
    if (ai == 'h31) return {3'd3, 2'd3, 2'b00, SnapEn};
    return 8'h00;
  endfunction

  // Scoreboard
  logic [7:0] exp_q [$];
  logic [6:0] addr_q [$];
  logic       issue = 1'b0;
  logic       rd_vld = 1'b0;

  always @(posedge CLK) rd_vld <= issue;

  always @(negedge CLK) begin
    if (hdr_update) upd_cnt++;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        logic [7:0] e;
        logic [6:0] a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("read_%02h", a), {24'h0, DATA_TO_MISO}, {24'h0, e});
      end
    end
  end

  // One clock of stimulus; the model is advanced to mirror the same edge.
  task automatic cyc(input bit en, input bit rd, input logic [6:0] a, input logic [7:0] d,
                     input bit chk);
    int ai;
    ai = int'(a);
    SPI_ENA = en;
    SPI_RD = rd;
    SPI_ADDRESS = a;
    SPI_DATA = d;
    if (chk) begin
      exp_q.push_back(m_read(a));
      addr_q.push_back(a);
      issue = 1'b1;
    end
    if (rd && SnapEn && ai >= 'h20 && ai < 'h30 && (ai - 'h20) % 4 == 0)
      m_snap[(ai - 'h20) / 4] = live_word((ai - 'h20) / 4);
    if (en) begin
      if (ai >= 'h10 && ai < 'h20) m_sh[ai - 'h10] = d;
      else if (ai == 'h30 && d == 8'hA5) begin
        for (int i = 0; i < 16; i++) m_act[i] = m_sh[i];
        exp_upd++;
      end else if (ai == 'h30 && d == 8'h5A) begin
        for (int i = 0; i < 16; i++) m_sh[i] = m_act[i];
      end
    end
    @(posedge CLK);
    #1;
    SPI_ENA = 1'b0;
    SPI_RD = 1'b0;
    issue = 1'b0;
  endtask

  task automatic check_hb(input logic [3:0] idx, input string name);
    header_byte_addr = idx;
    #1;
    check(name, {24'h0, header_byte}, {24'h0, m_act[idx]});
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    #3;
    m_reset();
    RST = 1'b1;
  endtask

  task automatic rand_bus();
    for (int c = 0; c < 4; c++) byterate_bus[c*32 +: 32] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Reset defaults
    header_byte_addr = 4'd4; #1; check("rst_hb4", {24'h0, header_byte}, 32'h01);
    header_byte_addr = 4'd5; #1; check("rst_hb5", {24'h0, header_byte}, 32'h03);
    header_byte_addr = 4'd7; #1; check("rst_hb7", {24'h0, header_byte}, 32'h00);
    check("rst_miso", {24'h0, DATA_TO_MISO}, 32'h00);
    check("rst_upd", {31'h0, hdr_update}, 32'h0);

    // Shadow write, readback, commit
    cyc(1, 0, 7'h14, 8'h7E, 0);
    header_byte_addr = 4'd4; #1; check("hb4_precommit", {24'h0, header_byte}, 32'h01);
    cyc(0, 0, 7'h14, 8'h00, 1);
    cyc(1, 0, 7'h30, 8'hA5, 0);
    header_byte_addr = 4'd4; #1; check("hb4_commit", {24'h0, header_byte}, 32'h7E);
    repeat (2) cyc(0, 0, 7'h00, 8'h00, 0);
    check("commit_pulses", upd_cnt, 1);

    // Revert discards pending edits
    cyc(1, 0, 7'h10, 8'h11, 0);
    cyc(1, 0, 7'h30, 8'h5A, 0);
    cyc(0, 0, 7'h10, 8'h00, 1);
    repeat (2) cyc(0, 0, 7'h00, 8'h00, 0);
    check("revert_no_pulse", upd_cnt, exp_upd);

    // Coherent multi-byte rate read
    byterate_bus[63:32] = 32'h12345678;
    cyc(0, 1, 7'h24, 8'h00, 1);
    byterate_bus[63:32] = 32'hFFFFFFFF;
    for (int k = 1; k < 4; k++) cyc(0, 1, 7'(8'h24 + k), 8'h00, 1);

    // Ignored command / out-of-window write, ID read
    cyc(1, 0, 7'h30, 8'h00, 0);
    cyc(1, 0, 7'h60, 8'h99, 0);
    cyc(0, 0, 7'h31, 8'h00, 1);
    for (int i = 0; i < 16; i++) check_hb(4'(i), "hb_after_ignored");

    // Reset between shadow write and commit
    cyc(1, 0, 7'h14, 8'h55, 0);
    cyc(0, 0, 7'h00, 8'h00, 0);
    pulse_reset();
    check_hb(4'd4, "hb4_after_rst");
    cyc(0, 0, 7'h14, 8'h00, 1);
    repeat (2) cyc(0, 0, 7'h00, 8'h00, 0);

    // Reset right after a commit edge drops the pending pulse
    cyc(1, 0, 7'h18, 8'hC3, 0);
    cyc(1, 0, 7'h30, 8'hA5, 0);
    exp_upd--;
    pulse_reset();
    repeat (2) cyc(0, 0, 7'h00, 8'h00, 0);
    check("pulse_dropped", upd_cnt, exp_upd);
    check_hb(4'd8, "hb8_after_rst");

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      int op;
      op = int'($urandom_range(0, 6));
      case (op)
        0: cyc(1, 0, 7'(8'h10 + $urandom_range(0, 15)), 8'($urandom), 0);
        1: cyc(1, 0, 7'h30, 8'hA5, 0);
        2: cyc(1, 0, 7'h30, 8'h5A, 0);
        3: cyc(0, 1'($urandom), 7'($urandom), 8'h00, 1);
        4: begin
          int c;
          c = int'($urandom_range(0, 3));
          cyc(0, 1, 7'(8'h20 + 4*c), 8'h00, 1);
          rand_bus();
          for (int k = 1; k < 4; k++) cyc(0, 1, 7'(8'h20 + 4*c + k), 8'h00, 1);
        end
        5: begin
          rand_bus();
          cyc(0, 0, 7'(8'h10 + $urandom_range(0, 31)), 8'h00, 1);
        end
        default: begin
          logic [7:0] d;
          d = 8'($urandom);
          if (d == 8'hA5 || d == 8'h5A) d = 8'h00;
          if ($urandom_range(0, 1) == 1) cyc(1, 0, 7'h30, d, 0);
          else cyc(1, 0, 7'(8'h20 + $urandom_range(0, 95)), d, 0);
        end
      endcase
      check_hb(4'($urandom), "hb_random");
    end

    repeat (3) cyc(0, 0, 7'h00, 8'h00, 0);
    check("final_pulses", upd_cnt, exp_upd);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
